// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider, unsigned or two's-complement signed.
// Fixed latency of WIDTH+2 cycles after start; divide-by-zero exits early.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    count_reg, count_next;
    logic [WIDTH:0]   rem_reg, rem_next;
    logic [WIDTH-1:0] quo_reg, quo_next;
    logic [WIDTH-1:0] dsr_reg, dsr_next;
    logic             qneg_reg, qneg_next;
    logic             rneg_reg, rneg_next;
    logic             dz_reg, dz_next;
    logic [WIDTH-1:0] quotient_reg, quotient_next;
    logic [WIDTH-1:0] remainder_reg, remainder_next;
    logic             dz_out_reg, dz_out_next;
    logic             busy_reg, busy_next;
    logic             done_reg, done_next;

    logic [WIDTH:0]   shifted;
    logic [WIDTH+1:0] trial;
    logic             dvd_neg;
    logic             dsr_neg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            count_reg     <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dsr_reg       <= '0;
            qneg_reg      <= 1'b0;
            rneg_reg      <= 1'b0;
            dz_reg        <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
            dz_out_reg    <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            count_reg     <= count_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dsr_reg       <= dsr_next;
            qneg_reg      <= qneg_next;
            rneg_reg      <= rneg_next;
            dz_reg        <= dz_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
            dz_out_reg    <= dz_out_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        count_next     = count_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dsr_next       = dsr_reg;
        qneg_next      = qneg_reg;
        rneg_next      = rneg_reg;
        dz_next        = dz_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;
        dz_out_next    = dz_out_reg;

        // Trial subtraction is one bit wider than R so its MSB is the borrow.
        shifted = {rem_reg[WIDTH-1:0], quo_reg[WIDTH-1]};
        trial   = {1'b0, shifted} - {2'b00, dsr_reg};
        dvd_neg = signed_op & dividend[WIDTH-1];
        dsr_neg = signed_op & divisor[WIDTH-1];

        case (state_reg)
            IDLE: begin
                if (start) begin
                    rem_next   = '0;
                    count_next = CW'(WIDTH - 1);
                    if (divisor == '0) begin
                        // Q carries the raw dividend through to the remainder output.
                        dz_next    = 1'b1;
                        quo_next   = dividend;
                        dsr_next   = '0;
                        qneg_next  = 1'b0;
                        rneg_next  = 1'b0;
                        state_next = FIX;
                    end else begin
                        dz_next    = 1'b0;
                        quo_next   = dvd_neg ? -dividend : dividend;
                        dsr_next   = dsr_neg ? -divisor : divisor;
                        qneg_next  = dvd_neg ^ dsr_neg;
                        rneg_next  = dvd_neg;
                        state_next = RUN;
                    end
                end
            end
            RUN: begin
                rem_next = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
                quo_next = {quo_reg[WIDTH-2:0], ~trial[WIDTH+1]};
                if (count_reg == '0) begin
                    state_next = FIX;
                end else begin
                    count_next = count_reg - CW'(1);
                end
            end
            FIX: begin
                if (dz_reg) begin
                    quotient_next  = '1;
                    remainder_next = quo_reg;
                end else begin
                    quotient_next  = qneg_reg ? -quo_reg : quo_reg;
                    remainder_next = rneg_reg ? -rem_reg[WIDTH-1:0] : rem_reg[WIDTH-1:0];
                end
                dz_out_next = dz_reg;
                state_next  = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        busy_next = (state_next != IDLE);
        done_next = (state_next == DONE);
    end

    assign busy        = busy_reg;
    assign done        = done_reg;
    assign quotient    = quotient_reg;
    assign remainder   = remainder_reg;
    assign div_by_zero = dz_out_reg;

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative radix-2 restoring divider for the multicycle datapath. The main control FSM launches it from the DIV execute states and holds in place until `done`. The result is written back through the ALU writeback path. Supports unsigned and signed (two's-complement) 32-bit division with fixed latency. Divide-by-zero takes an early exit.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `start`  in  1: launch request; accepted only when `busy`=0.
- `signed_op`  in  1: 1 = signed division, 0 = unsigned; sampled with `start`.
- `dividend`  in  WIDTH: numerator; sampled with `start`.
- `divisor`  in  WIDTH: denominator; sampled with `start`.
- `busy`  out  1: operation in progress.
- `done`  out  1: one-cycle pulse; results valid.
- `quotient`  out  WIDTH: quotient; held until the next accepted `start`.
- `remainder`  out  WIDTH: remainder; held until the next accepted `start`.
- `div_by_zero`  out  1: set with `done` when divisor was 0; held like results.

## Operation
- States:
  - IDLE: wait for `start`. Accepted `start` latches operands and goes to RUN, or to FIX if the divisor is zero.
  - RUN: one iteration per cycle, exactly WIDTH cycles. Step counter counts WIDTH-1 down to 0.
  - FIX: one cycle for sign correction and result register load.
  - DONE: one cycle, `done`=1, then IDLE.
- On accept:
  - Signed mode: magnitudes |dividend| and |divisor| are stored, and the sign flags are stored as qneg = sign(dividend) XOR sign(divisor), rneg = sign(dividend).
  - Unsigned mode: operands are stored raw and both flags are 0.
- RUN step:
  - Partial remainder `R` is WIDTH+1 bits; Q is a WIDTH-bit shift register initialised to |dividend|.
  - R' = {R[WIDTH-1:0], Q[WIDTH-1]}.
  - If R' - divisor ≥ 0: R = R' - divisor, shift 1 into Q. Otherwise R = R', shift 0 into Q.
- FIX: quotient = qneg ? -Q : Q and remainder = rneg ? -R[WIDTH-1:0] : R[WIDTH-1:0], both truncated to WIDTH.
  - The remainder sign always follows the dividend; the quotient truncates toward zero.
- Divide-by-zero: quotient = all ones and remainder = dividend (raw, unmodified), regardless of `signed_op`. `div_by_zero`=1 in this case, 0 otherwise.
- Signed overflow (most-negative / -1): the natural result quotient = 0x80000000 (WIDTH=32), remainder = 0, `div_by_zero`=0. No special handling.
- `start` while `busy`=1 is ignored; the operands at that time have no effect.
- `start` in the DONE cycle is ignored (`busy`=1 there). The earliest re-launch is the cycle after `done`.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0, counter 0.
- `reset` asserted in any state (mid-RUN included):
  - Returns to IDLE next edge.
  - No `done` pulse.
  - Outputs are forced to their reset values.
- `start` sampled high at edge k in IDLE:
  - `busy`=1 from cycle k+1 through the DONE cycle inclusive.
- Normal latency:
  - RUN occupies cycles k+1 … k+WIDTH and FIX is cycle k+WIDTH+1.
  - `done`=1 in cycle k+WIDTH+2 (k+34 for WIDTH=32).
- Divide-by-zero latency: FIX in k+1, `done` in k+2.
- `done` and `busy` both fall at the edge ending the DONE cycle.
- `quotient`/`remainder`/`div_by_zero` change only at the FIX→DONE edge and at reset. They are stable and valid when `done`=1 and remain held afterwards.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Unsigned 100 / 7, `start` at k → `done` at k+34 only; `quotient`=14, `remainder`=2, `div_by_zero`=0; `busy` high k+1…k+34.
- Signed -7 / 2 (0xFFFFFFF9 / 2) → `quotient`=0xFFFFFFFD (-3), `remainder`=0xFFFFFFFF (-1); same input with `signed_op`=0 → `quotient`=0x7FFFFFFC, `remainder`=1.
- Signed 0x80000000 / 0xFFFFFFFF → `quotient`=0x80000000, `remainder`=0. Unsigned 0xFFFFFFFF / 1 → `quotient`=0xFFFFFFFF, `remainder`=0.
- 5 / 0 (either mode), `start` at k → `done` at k+2, `quotient`=0xFFFFFFFF, `remainder`=5, `div_by_zero`=1. A following 9/3 clears `div_by_zero` and gives `quotient`=3.
- Launch 100/7, then pulse `start` with 50/5 at k+10 and at the DONE cycle → both ignored; the result stays 14/2 with a single `done`. A `start` the cycle after `done` is accepted.
- Launch 100/7, assert `reset` at k+15 for one cycle → `busy`=0, outputs 0 and no `done` through k+40. A fresh 9/4 then yields `quotient`=2, `remainder`=1 after 34 cycles.
